// File: rtl/mac_ctrl_defs.sv
// mac_ctrl_defs -- shared definitions for the dot-product MAC controller.
// Holds the controller state encoding and the default vector-length width.
// The systolic-array top-level sequencer imports the same package so both
// agree on state values when they are observed or forwarded.
package mac_ctrl_defs;

  // Default width of the vector-length field.
  localparam int LEN_W_DEF = 8;

  // Controller states.
  //   ST_IDLE  : waiting for start
  //   ST_RUN   : accepting operand pairs
  //   ST_DRAIN : last pair accepted, waiting for the multiply/accumulate pipe to empty
  //   ST_FLUSH : one-cycle accumulator clear / result-transfer strobe
  //   ST_DONE  : one-cycle done pulse, DSP result outputs valid
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mac_en_pipe.sv
// mac_en_pipe -- two-stage enable pipe that follows an accepted operand pair
// through the DSP multiply and accumulate stages.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   accept : an operand pair is loaded into the DSP a/b registers this cycle
//   flush  : synchronously empty the pipe at the next edge (cancels pending work)
//   men    : product-register enable (pair accepted one cycle ago)
//   sen    : accumulate enable (pair accepted two cycles ago)
//
// Kept as its own module so an array of processing elements can chain one per PE.
module mac_en_pipe (
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic flush,
  output logic men,
  output logic sen
);

  logic v1;
  logic v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
    end
  end

  // Bubbles on accept simply travel down the pipe as zeros, so the DSP
  // stages hold their contents on those cycles.
  assign men = v1;
  assign sen = v2;

endmodule

// File: rtl/mac_ctrl.sv
// mac_ctrl -- sequencer for one dot-product job on a DSP multiply-accumulate slice.
//
// A job starts on start (len sampled), accepts len operand pairs from a
// valid/ready source, lets the multiply/accumulate pipe drain, strobes the
// DSP accumulator clear/result transfer once, then pulses done. abort during
// the run or drain cancels outstanding work and ends the job with aborted=1.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset (the DSP shares it)
//   start    : begin one job (honoured only while idle)
//   len      : number of operand pairs, sampled with start
//   abort    : cancel the job in progress (honoured in RUN/DRAIN only)
//   in_valid : source presents an operand pair on the DSP a/b inputs
//   in_ready : pair is accepted this cycle
//   aen, ben : DSP operand-register load enables (equal to accept)
//   men      : DSP product-register enable
//   sen      : DSP accumulate enable
//   sreset   : DSP accumulator clear and result-transfer strobe
//   busy     : a job is in progress
//   done     : one-cycle pulse, DSP s_out/sat valid
//   aborted  : qualifies done, job ended by abort
module mac_ctrl
  import mac_ctrl_defs::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             aen,
  output logic             ben,
  output logic             men,
  output logic             sen,
  output logic             sreset,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] count;
  logic             aborted_flag;
  logic             accept;
  logic             abort_take;

  // abort only has an effect while there is work in flight.
  assign abort_take = abort & ((state == ST_RUN) | (state == ST_DRAIN));
  assign accept     = in_valid & in_ready;
  assign aen        = accept;
  assign ben        = accept;

  mac_en_pipe u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (accept),
    .flush  (abort_take),
    .men    (men),
    .sen    (sen)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (len == '0) ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_FLUSH;
        end else if (accept && (count == LEN_W'(1))) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // DRAIN never accepts, so once stage 1 is empty the whole pipe is
        // empty at the next edge and the flush strobe cannot overlap sen.
        if (abort || !men) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    sreset   = 1'b0;
    done     = 1'b0;
    aborted  = 1'b0;
    case (state)
      ST_IDLE:  busy = 1'b0;
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = ~abort;
      end
      ST_DRAIN: busy = 1'b1;
      ST_FLUSH: begin
        busy   = 1'b1;
        sreset = 1'b1;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        aborted = aborted_flag;
      end
      default:  busy = 1'b0;
    endcase
  end

  // Remaining-pair count. Loading len and counting down to 1 means the
  // all-ones length finishes without ever wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if ((state == ST_IDLE) && start) begin
      count <= len;
    end else if (accept) begin
      count <= count - LEN_W'(1);
    end
  end

  // Remembers that the current job was cancelled until its done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_flag <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      aborted_flag <= 1'b0;
    end else if (abort_take) begin
      aborted_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_ctrl.sv
// tb_mac_ctrl -- self-checking bench for mac_ctrl.
// A small behavioural DSP stand-in consumes the enables; a timeline model
// (per-job event cycles and per-cycle accept history) predicts every
// controller output each cycle and the DSP result at each done.
module tb_mac_ctrl;

  localparam int MAXC = 16384;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        len = 8'd0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready, aen, ben, men, sen, sreset, busy, done, aborted;
  logic signed [15:0] a = 16'sd0;
  logic signed [15:0] b = 16'sd0;

  mac_ctrl #(.LEN_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .aen      (aen),
    .ben      (ben),
    .men      (men),
    .sen      (sen),
    .sreset   (sreset),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
  );

  always #5 clk = ~clk;

  // ---------------- DSP stand-in ----------------
  function automatic longint sat_val(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic bit sat_flag(input longint v);
    return (v > 32767) || (v < -32768);
  endfunction

  logic signed [15:0] a_r, b_r, s_out;
  logic signed [31:0] p_r;
  logic signed [47:0] acc;
  logic               sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0; b_r <= '0; p_r <= '0; acc <= '0; s_out <= '0; sat <= 1'b0;
    end else begin
      if (aen) a_r <= a;
      if (ben) b_r <= b;
      if (men) p_r <= a_r * b_r;
      if (sreset) begin
        s_out <= 16'(sat_val(longint'(acc)));
        sat   <= sat_flag(longint'(acc));
        acc   <= '0;
      end else if (sen) begin
        acc <= acc + 48'(p_r);
      end
    end
  end

  // ---------------- checking infrastructure ----------------
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- timeline reference model ----------------
  bit     acc_at[MAXC];     // a pair was accepted in this cycle
  bit     killed_at[MAXC];  // an abort was taken in this cycle
  bit     m_live, m_run, m_abd;
  int     m_rem, m_flush, m_done, m_drain_until;
  longint prods[$];
  int     pcyc[$];

  // monitor statistics used by the directed pins
  int     cnt_aen = 0, cnt_sen = 0, cnt_srst = 0, cnt_done = 0;
  int     last_aen_cyc = 0, start_cyc = 0, srst_cyc = 0;
  int     first_men = -1, last_men = -1, first_sen = -1, last_sen = -1;
  longint last_s_out = 0;
  int     last_sat = 0, last_aborted = 0;

  task automatic model_reset();
    m_live = 0; m_run = 0; m_abd = 0; m_rem = 0;
    m_flush = -1; m_done = -1; m_drain_until = -1;
    prods.delete(); pcyc.delete();
  endtask

  initial model_reset();

  always @(negedge clk) begin
    int t;
    bit e_ir, e_acc, e_men, e_sen, e_srst, e_done, e_abd, e_busy, abortable;
    longint s;
    t = cyc;
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_aen", aen, 0);
      chk("rst_ben", ben, 0);
      chk("rst_men", men, 0);
      chk("rst_sen", sen, 0);
      chk("rst_sreset", sreset, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      model_reset();
    end else begin
      e_ir   = m_run && !abort;
      e_acc  = e_ir && in_valid;
      e_men  = (t >= 1) && acc_at[t-1];
      e_sen  = (t >= 2) && acc_at[t-2] && !killed_at[t-1];
      e_srst = (t == m_flush);
      e_done = (t == m_done);
      e_abd  = e_done && m_abd;
      e_busy = m_live;
      chk("in_ready", in_ready, e_ir);
      chk("aen", aen, e_acc);
      chk("ben", ben, e_acc);
      chk("men", men, e_men);
      chk("sen", sen, e_sen);
      chk("sreset", sreset, e_srst);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("aborted", aborted, e_abd);

      // statistics from the DUT side
      if (start && !busy) begin
        start_cyc = t; first_men = -1; last_men = -1; first_sen = -1; last_sen = -1;
      end
      if (aen) begin cnt_aen++; last_aen_cyc = t; end
      if (men) begin if (first_men < 0) first_men = t; last_men = t; end
      if (sen) begin cnt_sen++; if (first_sen < 0) first_sen = t; last_sen = t; end
      if (sreset) begin cnt_srst++; srst_cyc = t; end
      if (done) begin
        cnt_done++;
        last_s_out = longint'(s_out); last_sat = int'(sat); last_aborted = int'(aborted);
      end

      if (e_done) begin
        // a pair contributes unless an abort landed the cycle after its accept
        s = 0;
        foreach (pcyc[i]) if (!killed_at[pcyc[i]+1]) s += prods[i];
        chk("s_out", longint'(s_out), sat_val(s));
        chk("sat", sat, sat_flag(s));
      end

      // advance the model
      abortable = m_run || (m_live && (t <= m_drain_until));
      if (abortable && abort) begin
        killed_at[t] = 1;
        m_run = 0; m_drain_until = -1; m_abd = 1;
        m_flush = t + 1; m_done = t + 2;
      end else if (e_acc) begin
        acc_at[t] = 1;
        pcyc.push_back(t);
        prods.push_back(longint'(a) * longint'(b));
        m_rem--;
        if (m_rem == 0) begin
          m_run = 0; m_drain_until = t + 2; m_flush = t + 3; m_done = t + 4;
        end
      end
      if (e_done) begin
        m_live = 0;
      end else if (!m_live && start) begin
        m_live = 1; m_abd = 0; prods.delete(); pcyc.delete();
        if (len == 8'd0) begin
          m_flush = t + 1; m_done = t + 2;
        end else begin
          m_run = 1; m_rem = int'(len);
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  int pa[256];
  int pb[256];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int d0;
    d0 = cnt_done;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (cnt_done != d0) break;
    end
    #1;
    chk(nm, cnt_done - d0, 1);
  endtask

  // One job: pairs from pa/pb, optional bubble run after pair gap_after,
  // optional abort presented with pair abort_idx, optional stray start on
  // loop iteration busy_start_at, optional reset pulse once in DRAIN.
  task automatic run_job(input int n, input int gap_after, input int gap_len,
                         input int abort_idx, input int busy_start_at, input bit rst_drain,
                         input string nm);
    int idx, gap, guard;
    bit stop, accepted, ab;
    start = 1'b1; len = 8'(n);
    step();
    start = 1'b0;
    idx = 0; gap = 0; guard = 0; stop = (n == 0);
    while (!stop && guard < 1000) begin
      guard++;
      start = (guard == busy_start_at);
      if (start) len = 8'd9;
      if (gap > 0) begin
        in_valid = 1'b0; gap--;
      end else begin
        in_valid = 1'b1; a = 16'(pa[idx]); b = 16'(pb[idx]); abort = (idx == abort_idx);
      end
      @(negedge clk);
      accepted = in_valid && in_ready;
      ab = abort;
      step();
      in_valid = 1'b0; abort = 1'b0; start = 1'b0;
      if (ab) stop = 1;
      else if (accepted) begin
        idx++;
        if (idx - 1 == gap_after) gap = gap_len;
        if (idx >= n) stop = 1;
      end
    end
    if (!stop) chk({nm, "_accepts"}, idx, n);
    if (rst_drain) begin
      // now one cycle after the final accept: the controller is draining
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
    end else begin
      wait_done({nm, "_done"});
    end
  endtask

  int b_aen, b_sen, b_srst, b_done;

  task automatic snap();
    b_aen = cnt_aen; b_sen = cnt_sen; b_srst = cnt_srst; b_done = cnt_done;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // len=4, continuous pairs: 2+12+30+56 = 100
    pa[0:3] = '{1, 3, 5, 7}; pb[0:3] = '{2, 4, 6, 8};
    snap();
    run_job(4, -1, 0, -1, 0, 0, "t1");
    chk("t1_aen_cnt", cnt_aen - b_aen, 4);
    chk("t1_sen_cnt", cnt_sen - b_sen, 4);
    chk("t1_sreset_cnt", cnt_srst - b_srst, 1);
    chk("t1_done_lat", cyc - 1 - last_aen_cyc, 4);
    chk("t1_s_out", last_s_out, 100);
    chk("t1_sat", last_sat, 0);
    chk("t1_aborted", last_aborted, 0);
    step();

    // len=3, two bubbles after the first pair: 6+20-6 = 20
    pa[0:2] = '{2, 4, -1}; pb[0:2] = '{3, 5, 6};
    snap();
    run_job(3, 0, 2, -1, 0, 0, "t2");
    chk("t2_sen_cnt", cnt_sen - b_sen, 3);
    chk("t2_men_span", last_men - first_men, 4);
    chk("t2_sen_span", last_sen - first_sen, 4);
    chk("t2_s_out", last_s_out, 20);
    step();

    // len=0: straight to the flush strobe
    snap();
    run_job(0, -1, 0, -1, 0, 0, "t3");
    chk("t3_flush_lat", srst_cyc - start_cyc, 1);
    chk("t3_aen_cnt", cnt_aen - b_aen, 0);
    chk("t3_sen_cnt", cnt_sen - b_sen, 0);
    chk("t3_aborted", last_aborted, 0);
    chk("t3_s_out", last_s_out, 0);
    step();

    // len=8, abort with the 3rd pair (after the pipe has drained): 1*2+2*3 = 8
    for (int i = 0; i < 8; i++) begin pa[i] = i + 1; pb[i] = i + 2; end
    snap();
    run_job(8, 1, 2, 2, 0, 0, "t4");
    chk("t4_aen_cnt", cnt_aen - b_aen, 2);
    chk("t4_sen_cnt", cnt_sen - b_sen, 2);
    chk("t4_sreset_cnt", cnt_srst - b_srst, 1);
    chk("t4_aborted", last_aborted, 1);
    chk("t4_s_out", last_s_out, 8);
    step();

    // saturation, plus a start while busy that must be ignored
    pa[0:1] = '{32767, 32767}; pb[0:1] = '{32767, 32767};
    snap();
    run_job(2, -1, 0, -1, 2, 0, "t5");
    repeat (8) step();
    chk("t5_s_out", last_s_out, 32767);
    chk("t5_sat", last_sat, 1);
    chk("t5_done_cnt", cnt_done - b_done, 1);
    chk("t5_aen_cnt", cnt_aen - b_aen, 2);

    // reset while draining: no done, then a clean job 5*5 = 25
    pa[0:2] = '{3, 4, 5}; pb[0:2] = '{1, 1, 1};
    snap();
    run_job(3, -1, 0, -1, 0, 1, "t6");
    repeat (8) step();
    chk("t6_no_done", cnt_done - b_done, 0);
    pa[0] = 5; pb[0] = 5;
    run_job(1, -1, 0, -1, 0, 0, "t6b");
    chk("t6b_s_out", last_s_out, 25);
    step();

    // maximum length completes without wrap-around
    for (int i = 0; i < 255; i++) begin
      pa[i] = int'($urandom_range(20)) - 10; pb[i] = int'($urandom_range(20)) - 10;
    end
    snap();
    run_job(255, -1, 0, -1, 0, 0, "t7");
    chk("t7_aen_cnt", cnt_aen - b_aen, 255);
    chk("t7_done_cnt", cnt_done - b_done, 1);
    step();

    // free-running random traffic, one reset pulse in the middle
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(7) == 0);
      len      = ($urandom_range(9) == 0) ? 8'($urandom_range(20)) : 8'($urandom_range(5));
      in_valid = ($urandom_range(9) < 7);
      abort    = ($urandom_range(24) == 0);
      if ($urandom_range(3) == 0) begin
        a = 16'($urandom); b = 16'($urandom);
      end else begin
        a = 16'(int'($urandom_range(200)) - 100); b = 16'(int'($urandom_range(200)) - 100);
      end
      if (i == 1500) rst_n = 1'b0;
      if (i == 1502) rst_n = 1'b1;
      step();
    end
    start = 1'b0; in_valid = 1'b0; abort = 1'b0;
    repeat (30) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_W, default 8, meaning the width of the vector-length field.
REQ-002 The block SHALL have port clk, input, 1, meaning system clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, meaning a request to begin one dot-product job.
REQ-005 The block SHALL have port len, input, LEN_W, meaning the number of operand pairs in the job, sampled on start.
REQ-006 The block SHALL have port abort, input, 1, meaning cancel the job in progress.
REQ-007 The block SHALL have port in_valid, input, 1, meaning the source presents one operand pair to the DSP a/b inputs.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the controller accepts the presented pair this cycle.
REQ-009 The block SHALL have ports aen and ben, output, 1 each, meaning the DSP operand-register load enables.
REQ-010 The block SHALL have port men, output, 1, meaning the DSP product-register enable.
REQ-011 The block SHALL have port sen, output, 1, meaning the DSP accumulate enable.
REQ-012 The block SHALL have port sreset, output, 1, meaning the DSP accumulator clear and result-transfer strobe.
REQ-013 The block SHALL have port busy, output, 1, meaning a job is in progress.
REQ-014 The block SHALL have port done, output, 1, meaning a one-cycle pulse when the DSP result outputs (s_out/sat) are valid.
REQ-015 The block SHALL have port aborted, output, 1, meaning qualifies done; high when the job ended by abort.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, FLUSH and DONE.
- IDLE->RUN on start with len!=0.
- IDLE->FLUSH on start with len==0.
REQ-017 On start in IDLE, len SHALL be loaded into a remaining-count register; start in any other state SHALL be ignored.
REQ-018 in_ready SHALL equal (state==RUN) & ~abort; accept = in_valid & in_ready.
REQ-019 aen and ben SHALL both equal accept, combinationally, in the same cycle.
REQ-020 A 2-stage valid pipe SHALL be maintained (v1 <= accept; v2 <= v1), with men=v1 and sen=v2, so that the pair accepted in cycle c is multiplied at c+1 and accumulated at c+2.
REQ-021 An in_valid bubble SHALL propagate as bubbles; the DSP holds its state when the enables are low.
REQ-022 Each accept SHALL decrement the remaining count; the accept that brings it to 0 SHALL move the FSM RUN->DRAIN.
REQ-023 DRAIN SHALL last until v1 and v2 are both 0, then move to FLUSH; the last accept at cycle L gives sen at L+2 and FLUSH at L+3.
REQ-024 FLUSH SHALL assert sreset for exactly one cycle, never in the same cycle as sen, then move to DONE.
REQ-025 DONE SHALL pulse done for one cycle (L+4 after the last accept), then return to IDLE.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 abort in RUN or DRAIN SHALL:
- force in_ready, aen, ben to 0 that cycle;
- clear v1 and v2 at the next edge;
- go to FLUSH, then DONE with aborted=1 in the done cycle.
REQ-028 abort in IDLE, FLUSH or DONE SHALL be ignored; abort together with start in IDLE SHALL be ignored and the job SHALL start.
REQ-029 abort in the same cycle as a would-be final accept SHALL win: no accept, aborted=1.
REQ-030 The remaining-count register SHALL be LEN_W bits; len=2^LEN_W-1 SHALL complete without wrap-around.

Reset
REQ-031 On rst_n low, state SHALL be IDLE; count, v1 and v2 SHALL be 0; in_ready, aen, ben, men, sen, sreset, busy, done and aborted SHALL all be 0.
REQ-032 Reset mid-job SHALL abandon the job with no done pulse; the DSP is reset by the same rst_n.

Structure
REQ-033 State encodings and the default LEN_W SHALL reside in the shared header mac_ctrl_defs, reused by the systolic-array top-level sequencer.
REQ-034 The valid pipe SHALL be a sub-module, mac_en_pipe (accept in; men, sen out; flush input), so the array can chain it per PE.
REQ-035 All FSM outputs except aen, ben and in_ready SHALL be registered or decoded from registered state, with no combinational path from in_valid to men, sen or sreset.

Verification
REQ-036 The bench SHALL cover: len=4, in_valid held high, pairs (1,2),(3,4),(5,6),(7,8) -> aen for 4 cycles, sen for 4 cycles, one sreset, done 4 cycles after the last accept, DSP s_out=100, sat=0.
REQ-037 The bench SHALL cover: len=3, in_valid low for 2 cycles after the first pair, pairs (2,3),(4,5),(-1,6) -> men/sen show the same gap, s_out=20.
REQ-038 The bench SHALL cover: len=0 -> FLUSH next cycle, no aen/sen, done with aborted=0, s_out=0.
REQ-039 The bench SHALL cover: len=8 with abort asserted with the 3rd pair -> only 2 accepts, sen count=2, sreset once, done with aborted=1.
REQ-040 The bench SHALL cover: len=2, pairs (32767,32767) x2 -> s_out=0x7FFF, sat=1; then start during busy is ignored and the job's done count is 1.
REQ-041 The bench SHALL cover: rst_n pulsed low in DRAIN -> all outputs 0 immediately, no done, and the next job (len=1, (5,5)) gives s_out=25.
